// File: rtl/cp0_pkg.sv
// CP0 shared header: constants common to the CP0 register blocks.
package cp0_pkg;

  localparam int CP0_WIDTH      = 32;
  localparam int CP0_RESET_VAL  = 0;
  localparam int CP0_DEPTH_MAX  = 16;

endpackage

// File: rtl/nested_badvinstr_stack.sv
// Nested BadVInstr stack: keeps the faulting instruction word of each
// nested exception level. Entry 0 is the top; pushes shift entries toward
// the bottom, erets shift them back up. irq levels carry a zero word.
module nested_badvinstr_stack
  import cp0_pkg::*;
#(
  parameter int WIDTH = CP0_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exc_take,
  input  logic                       irq,
  input  logic                       exception_abort,
  input  logic                       eret,
  input  logic [WIDTH-1:0]           badvinstr_p,
  input  logic                       mtc0_we,
  input  logic [WIDTH-1:0]           mtc0_data,
  input  logic                       clr_flags,
  output logic [WIDTH-1:0]           read_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(CP0_RESET_VAL);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push;
  logic [WIDTH-1:0] push_val;
  logic             empty;
  logic             full;

  assign push     = (exc_take | irq) & ~exception_abort;
  // exc_take takes precedence so a coincident irq still records the fault word
  assign push_val = exc_take ? badvinstr_p : '0;
  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_FULL);

  // Next-state for entries, level and sticky flags
  always_comb begin
    entries_d   = entries_q;
    level_d     = level_q;
    overflow_d  = clr_flags ? 1'b0 : overflow_q;
    underflow_d = clr_flags ? 1'b0 : underflow_q;

    if (push && eret) begin
      // return and re-entry in the same cycle: the top is simply replaced
      entries_d[0] = push_val;
      if (empty) level_d = LW'(1);
    end else if (push) begin
      for (int i = DEPTH-1; i > 0; i--) entries_d[i] = entries_q[i-1];
      entries_d[0] = push_val;
      if (full) overflow_d = 1'b1;
      else      level_d    = level_q + LW'(1);
    end else if (eret) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH-1; i++) entries_d[i] = entries_q[i+1];
        entries_d[DEPTH-1] = RST_WORD;
        level_d = level_q - LW'(1);
      end
    end else if (mtc0_we && !empty) begin
      entries_d[0] = mtc0_data;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= RST_WORD;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Top entry is only visible while the stack holds something; the explicit
  // rst term keeps the output at zero for the whole reset pulse
  always_comb begin
    read_data = RST_WORD;
    if (!rst && !empty) read_data = entries_q[0];
  end

  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_nested_badvinstr_stack.sv
module tb_nested_badvinstr_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_take, irq, exception_abort, eret, mtc0_we, clr_flags;
  logic [31:0] badvinstr_p, mtc0_data;
  logic [31:0] read_data;
  logic [2:0]  level;
  logic        overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  nested_badvinstr_stack #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .exc_take(exc_take), .irq(irq), .exception_abort(exception_abort),
    .eret(eret), .badvinstr_p(badvinstr_p),
    .mtc0_we(mtc0_we), .mtc0_data(mtc0_data), .clr_flags(clr_flags),
    .read_data(read_data), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    exc_take = 0; irq = 0; exception_abort = 0; eret = 0;
    mtc0_we = 0; clr_flags = 0; badvinstr_p = '0; mtc0_data = '0;
  endtask

  // apply one cycle of inputs, return 1 time unit after the edge
  task automatic cyc(input logic e, input logic i, input logic a, input logic r,
                     input logic w, input logic c,
                     input logic [31:0] bv, input logic [31:0] md);
    exc_take = e; irq = i; exception_abort = a; eret = r;
    mtc0_we = w; clr_flags = c; badvinstr_p = bv; mtc0_data = md;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL reset_read: got %h want 0", read_data); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_push_pop();
    do_reset();
    cyc(1,0,0,0,0,0,32'hA0000001,0);
    n_cmp++; if (read_data !== 32'hA0000001) begin n_err++; $display("FAIL pp_first: got %h want a0000001", read_data); end
    cyc(1,0,0,0,0,0,32'hA0000002,0);
    cyc(1,0,0,0,0,0,32'hA0000003,0);
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL pp_level3: got %0d want 3", level); end
    n_cmp++; if (read_data !== 32'hA0000003) begin n_err++; $display("FAIL pp_top3: got %h want a0000003", read_data); end
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if (read_data !== 32'hA0000002) begin n_err++; $display("FAIL pp_pop1: got %h want a0000002", read_data); end
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if (read_data !== 32'hA0000001) begin n_err++; $display("FAIL pp_pop2: got %h want a0000001", read_data); end
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL pp_pop3: got %h want 0", read_data); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL pp_level0: got %0d want 0", level); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL pp_flags: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pop [4] = '{32'h4, 32'h3, 32'h2, 32'h0};
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1,0,0,0,0,0,32'(k),0);
    n_cmp++; if ({level, overflow} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL ov_full_noflag: got lvl %0d ov %b want 4 0", level, overflow); end
    cyc(1,0,0,0,0,0,32'h5,0);
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ov_level: got %0d want 4", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_flag: got %b want 1", overflow); end
    n_cmp++; if (read_data !== 32'h5) begin n_err++; $display("FAIL ov_top: got %h want 5", read_data); end
    for (int k = 0; k < 4; k++) begin
      cyc(0,0,0,1,0,0,0,0);
      n_cmp++; if (read_data !== exp_pop[k]) begin n_err++; $display("FAIL ov_pop%0d: got %h want %h", k, read_data, exp_pop[k]); end
    end
    n_cmp++; if ({level, underflow} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL ov_drained: got lvl %0d uf %b want 0 0", level, underflow); end
    cyc(0,0,0,0,0,1,0,0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ov_clear: got %b want 0", overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b want 1", underflow); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL uf_level: got %0d want 0", level); end
    cyc(0,0,0,0,0,1,0,0);
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b want 0", underflow); end
    // set beats clear in the same cycle
    cyc(0,0,0,1,0,1,0,0);
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_wins: got %b want 1", underflow); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL uf_no_ov: got %b want 0", overflow); end
  endtask

  task automatic test_replace_abort();
    do_reset();
    // eret+push on empty stack gives level 1, no underflow
    cyc(1,0,0,1,0,0,32'h9,0);
    n_cmp++; if ({level, underflow, read_data} !== {3'd1, 1'b0, 32'h9}) begin n_err++; $display("FAIL rp_empty: got lvl %0d uf %b rd %h want 1 0 9", level, underflow, read_data); end
    do_reset();
    cyc(1,0,0,0,0,0,32'hA,0);
    cyc(1,0,0,0,0,0,32'hB,0);
    cyc(1,0,0,1,0,0,32'hC,0);
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL rp_level: got %0d want 2", level); end
    n_cmp++; if (read_data !== 32'hC) begin n_err++; $display("FAIL rp_top: got %h want c", read_data); end
    cyc(1,0,1,0,0,0,32'hE,0);
    n_cmp++; if ({level, read_data} !== {3'd2, 32'hC}) begin n_err++; $display("FAIL rp_abort_exc: got lvl %0d rd %h want 2 c", level, read_data); end
    cyc(0,1,1,0,0,0,0,0);
    n_cmp++; if ({level, read_data} !== {3'd2, 32'hC}) begin n_err++; $display("FAIL rp_abort_irq: got lvl %0d rd %h want 2 c", level, read_data); end
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if (read_data !== 32'hA) begin n_err++; $display("FAIL rp_below: got %h want a", read_data); end
  endtask

  task automatic test_irq_mtc0();
    do_reset();
    cyc(1,0,0,0,0,0,32'h77,0);
    cyc(0,1,0,0,0,0,32'h55,0);
    n_cmp++; if ({level, read_data} !== {3'd2, 32'h0}) begin n_err++; $display("FAIL irq_push: got lvl %0d rd %h want 2 0", level, read_data); end
    cyc(0,0,0,0,1,0,0,32'hDEAD);
    n_cmp++; if ({level, read_data} !== {3'd2, 32'hDEAD}) begin n_err++; $display("FAIL mtc0_write: got lvl %0d rd %h want 2 dead", level, read_data); end
    // write ignored when a push happens the same cycle; exc+irq pushes the word
    cyc(1,1,0,0,1,0,32'h66,32'hBEEF);
    n_cmp++; if ({level, read_data} !== {3'd3, 32'h66}) begin n_err++; $display("FAIL mtc0_vs_push: got lvl %0d rd %h want 3 66", level, read_data); end
    cyc(0,0,0,1,1,0,0,32'hBEEF);
    n_cmp++; if (read_data !== 32'hDEAD) begin n_err++; $display("FAIL mtc0_vs_eret: got %h want dead", read_data); end
    cyc(0,0,0,1,0,0,0,0);
    n_cmp++; if ({level, read_data} !== {3'd1, 32'h77}) begin n_err++; $display("FAIL irq_restore: got lvl %0d rd %h want 1 77", level, read_data); end
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,32'h1234);
    n_cmp++; if ({level, read_data} !== {3'd0, 32'h0}) begin n_err++; $display("FAIL mtc0_empty: got lvl %0d rd %h want 0 0", level, read_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1,0,0,0,0,0,32'h11,0);
    cyc(1,0,0,0,0,0,32'h22,0);
    cyc(1,0,0,0,0,0,32'h33,0);
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,1,0,0,0,0);
    cyc(1,0,0,0,0,0,32'h11,0);
    cyc(1,0,0,0,0,0,32'h22,0);
    cyc(1,0,0,0,0,0,32'h33,0);
    n_cmp++; if ({level, underflow} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL ar_pre: got lvl %0d uf %b want 3 1", level, underflow); end
    exc_take = 1; badvinstr_p = 32'h44;
    #1;
    rst = 1;
    #1;
    n_cmp++; if ({level, read_data, overflow, underflow} !== {3'd0, 32'h0, 2'b00}) begin n_err++; $display("FAIL ar_immediate: got lvl %0d rd %h ov %b uf %b want 0 0 0 0", level, read_data, overflow, underflow); end
    @(posedge clk); #1;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL ar_held: got %0d want 0", level); end
    rst = 0;
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++; if ({level, read_data} !== {3'd1, 32'h44}) begin n_err++; $display("FAIL ar_first_edge: got lvl %0d rd %h want 1 44", level, read_data); end
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace_abort();
    test_irq_mtc0();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nested_badvinstr_stack.md
NESTED_BADVINSTR_STACK -- requirements
Module: nested_badvinstr_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of a captured faulting instruction word.
REQ-002 SHALL have parameter DEPTH, default 4: nesting depth (number of stacked entries); legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port exc_take  input  1  exception committed this cycle; capture badvinstr_p.
REQ-006 SHALL have port irq  input  1  interrupt committed this cycle; push a zero entry.
REQ-007 SHALL have port exception_abort  input  1  cancels any exc_take or irq push in the same cycle.
REQ-008 SHALL have port eret  input  1  exception return; pop the top entry.
REQ-009 SHALL have port badvinstr_p  input  WIDTH  faulting instruction word from the pipeline.
REQ-010 SHALL have port mtc0_we  input  1  software write to the top entry.
REQ-011 SHALL have port mtc0_data  input  WIDTH  data for the software write.
REQ-012 SHALL have port clr_flags  input  1  clears both sticky flags.
REQ-013 SHALL have port read_data  output  WIDTH  current top entry.
REQ-014 SHALL have port level  output  $clog2(DEPTH+1)  number of valid entries.
REQ-015 SHALL have port overflow  output  1  sticky flag; a push occurred while the stack was full.
REQ-016 SHALL have port underflow  output  1  sticky flag; an eret occurred while the stack was empty.

Function
REQ-017 SHALL define push = (exc_take | irq) & ~exception_abort.
REQ-018 SHALL push badvinstr_p when exc_take=1, and all-zeros when only irq=1.
REQ-019 SHALL treat exc_take and irq asserted together as a single push of badvinstr_p.
REQ-020 SHALL, on push with level<DEPTH, place the new entry on top and increment level by 1.
REQ-021 SHALL, on push with level==DEPTH, place the new entry on top, discard the bottom (oldest) entry, leave level unchanged, and set overflow.
REQ-022 SHALL, on eret with level>0 and no push, remove the top entry, expose the next entry, and decrement level.
REQ-023 SHALL, on eret with level==0 and no push, leave the entries unchanged and set underflow.
REQ-024 SHALL, on simultaneous eret and push, replace the top entry with the pushed value: level unchanged if level>0, level=1 if level==0; no flag set.
REQ-025 SHALL, on mtc0_we with level>0 and no push or eret, overwrite the top entry with mtc0_data.
REQ-026 SHALL ignore mtc0_we when level==0 or when push or eret is active in the same cycle.
REQ-027 SHALL drive read_data = top entry when level>0 and all-zeros when level==0; combinational from registered state.
REQ-028 SHALL make a push, pop or write visible on read_data and level exactly one cycle after the triggering edge.
REQ-029 SHALL clear overflow and underflow on clr_flags; a flag set in the same cycle SHALL win over clr_flags.
REQ-030 SHALL leave the contents of unused (above-level) entries unobservable on any output.

Reset
REQ-031 SHALL, while rst=1, force level=0, all entries to 0, overflow=0, underflow=0, and read_data=0, regardless of clk.
REQ-032 SHALL discard any push, pop or write in progress when rst asserts mid-operation; first update occurs on the first rising edge after deassertion.

Structure
REQ-033 SHALL take shared constants (default WIDTH 32, reset value 0, max DEPTH 16) from the existing CP0 shared header; no new package.
REQ-034 SHALL implement storage as a DEPTH-entry shift register (entry 0 = top) plus a level counter; flat design with no sub-module.

Verification
REQ-035 Reset then 3 exc_take pushes of 0xA0000001, 0xA0000002, 0xA0000003 -> level=3, read_data=0xA0000003; 3 erets -> read_data 0xA0000002, then 0xA0000001, then 0, level=0.
REQ-036 DEPTH=4: 5 pushes 0x1..0x5 -> level=4, overflow=1; 4 erets -> read_data sequence 0x4, 0x3, 0x2, then 0 (0x1 discarded).
REQ-037 Empty stack, eret -> underflow=1, level=0; clr_flags -> underflow=0 next cycle.
REQ-038 level=2 (top 0xB), exc_take+eret with badvinstr_p=0xC -> level=2, read_data=0xC; exc_take+exception_abort -> no change.
REQ-039 irq alone at level=1 -> level=2, read_data=0; mtc0_we data 0xDEAD -> read_data=0xDEAD; eret -> prior top restored.
REQ-040 rst pulse asserted mid-cycle at level=3 -> outputs zero immediately, before the next clk edge.
